event_tracker: RTL and testbench

EVENT_TRACKER -- requirements
Module: event_tracker

---
 rtl/event_tracker_pkg.sv | 22 ++
 rtl/event_tracker_chan.sv | 63 ++++++
 rtl/event_tracker.sv | 78 +++++++
 tb/tb_event_tracker.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/event_tracker_pkg.sv
// Shared definitions for the event tracker: parameter defaults, the last_id
// width helper and the per-channel state record.
package event_tracker_pkg;

  localparam int unsigned NChDefault  = 4;
  localparam int unsigned CntWDefault = 8;
  // Widest counter any channel may be built with; the state record is sized for it.
  localparam int unsigned CntMaxW     = 16;

  // Per-channel state: sticky event flag, saturating count, saturation flag.
  typedef struct packed {
    logic               flag;
    logic [CntMaxW-1:0] count;
    logic               sat;
  } chan_state_t;

  // Width of a channel index; never narrower than one bit.
  function automatic int unsigned id_w(input int unsigned n_ch);
    return (n_ch <= 1) ? 1 : $clog2(n_ch);
  endfunction

endpackage

// File: rtl/event_tracker_chan.sv
// Single event-tracker channel.
//   clk_i    : clock, all state on posedge
//   rst_ni   : synchronous active-low reset
//   acc_i    : accepted event this cycle (trig & en)
//   clr_i    : clear sticky flag, counter and saturation flag
//   pulse_o  : registered one-cycle pulse per accepted event
//   flag_o   : sticky "event has fired"
//   cnt_o    : saturating event count
//   sat_o    : sticky "event arrived while counter was full"
module event_tracker_chan
  import event_tracker_pkg::*;
#(
  parameter int unsigned CntW = CntWDefault
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            acc_i,
  input  logic            clr_i,
  output logic            pulse_o,
  output logic            flag_o,
  output logic [CntW-1:0] cnt_o,
  output logic            sat_o
);

  localparam logic [CntMaxW-1:0] CntMax = CntMaxW'((32'd1 << CntW) - 32'd1);

  chan_state_t state_d, state_q;
  logic        pulse_d, pulse_q;

  always_comb begin
    state_d      = state_q;
    pulse_d      = acc_i;
    // A same-cycle event wins over clear so it is never lost.
    state_d.flag = acc_i | (state_q.flag & ~clr_i);
    if (clr_i) begin
      // Clear restarts the count, counting a coincident event.
      state_d.count = {{(CntMaxW-1){1'b0}}, acc_i};
      state_d.sat   = 1'b0;
    end else if (acc_i) begin
      if (state_q.count == CntMax) begin
        state_d.sat = 1'b1;
      end else begin
        state_d.count = state_q.count + CntMaxW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pulse_q <= pulse_d;
    end
  end

  assign pulse_o = pulse_q;
  assign flag_o  = state_q.flag;
  assign cnt_o   = state_q.count[CntW-1:0];
  assign sat_o   = state_q.sat;

endmodule

// File: rtl/event_tracker.sv
// Multi-channel event tracker: per-channel pulse, sticky flag and saturating
// counter, plus the lowest-index most recent channel and global status.
//   clk        : clock;  rst_n : synchronous active-low reset
//   trig/en/clr: per-channel event strobe, enable mask, clear
//   triggered  : registered pulse per accepted event
//   last_event : sticky per-channel event bitmap; irq is its OR
//   cnt        : packed counts, channel i at [i*CNT_W +: CNT_W]
//   sat        : sticky per-channel saturation flags
//   last_id    : lowest channel accepted in the most recent accepting cycle
//   any_valid  : any event accepted since reset
module event_tracker
  import event_tracker_pkg::*;
#(
  parameter int unsigned N_CH  = NChDefault,
  parameter int unsigned CNT_W = CntWDefault,
  localparam int unsigned ID_W = id_w(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH-1:0]       trig,
  input  logic [N_CH-1:0]       en,
  input  logic [N_CH-1:0]       clr,
  output logic [N_CH-1:0]       triggered,
  output logic [N_CH-1:0]       last_event,
  output logic [N_CH*CNT_W-1:0] cnt,
  output logic [N_CH-1:0]       sat,
  output logic [ID_W-1:0]       last_id,
  output logic                  any_valid,
  output logic                  irq
);

  logic [N_CH-1:0] acc;
  logic [ID_W-1:0] last_id_d, last_id_q;
  logic            any_valid_d, any_valid_q;

  assign acc = trig & en;

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_chan
    event_tracker_chan #(
      .CntW (CNT_W)
    ) u_chan (
      .clk_i   (clk),
      .rst_ni  (rst_n),
      .acc_i   (acc[ch]),
      .clr_i   (clr[ch]),
      .pulse_o (triggered[ch]),
      .flag_o  (last_event[ch]),
      .cnt_o   (cnt[ch*CNT_W +: CNT_W]),
      .sat_o   (sat[ch])
    );
  end

  always_comb begin
    last_id_d = last_id_q;
    // Scan high to low so the lowest accepted index is written last.
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (acc[i]) begin
        last_id_d = ID_W'(i);
      end
    end
    any_valid_d = any_valid_q | (|acc);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_id_q   <= '0;
      any_valid_q <= 1'b0;
    end else begin
      last_id_q   <= last_id_d;
      any_valid_q <= any_valid_d;
    end
  end

  assign last_id   = last_id_q;
  assign any_valid = any_valid_q;
  assign irq       = |last_event;

endmodule

// File: tb/tb_event_tracker.sv
module tb_event_tracker;

  localparam int NCh = 4;
  localparam int WA  = 8;
  localparam int WB  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NCh-1:0] trig = '0, en = '0, clr = '0;

  logic [NCh-1:0]    trg_a, lev_a, sat_a, trg_b, lev_b, sat_b;
  logic [NCh*WA-1:0] cnt_a;
  logic [NCh*WB-1:0] cnt_b;
  logic [1:0]        id_a, id_b;
  logic              any_a, any_b, irq_a, irq_b;

  event_tracker #(.N_CH(NCh), .CNT_W(WA)) dut_a (
    .clk(clk), .rst_n(rst_n), .trig(trig), .en(en), .clr(clr),
    .triggered(trg_a), .last_event(lev_a), .cnt(cnt_a), .sat(sat_a),
    .last_id(id_a), .any_valid(any_a), .irq(irq_a)
  );

  event_tracker #(.N_CH(NCh), .CNT_W(WB)) dut_b (
    .clk(clk), .rst_n(rst_n), .trig(trig), .en(en), .clr(clr),
    .triggered(trg_b), .last_event(lev_b), .cnt(cnt_b), .sat(sat_b),
    .last_id(id_b), .any_valid(any_b), .irq(irq_b)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [NCh-1:0] m_trig, m_flag, m_sat_a, m_sat_b;
  int             m_cnt_a[NCh];
  int             m_cnt_b[NCh];
  int             m_id;
  logic           m_any;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic [NCh-1:0] t, e, c);
    logic [NCh-1:0] acc;
    bit found;
    acc   = t & e;
    found = 0;
    if (!r) begin
      m_trig = '0; m_flag = '0; m_sat_a = '0; m_sat_b = '0;
      m_id = 0; m_any = 1'b0;
      for (int i = 0; i < NCh; i++) begin
        m_cnt_a[i] = 0;
        m_cnt_b[i] = 0;
      end
    end else begin
      for (int i = 0; i < NCh; i++) begin
        m_trig[i] = acc[i];
        if (acc[i]) m_flag[i] = 1'b1;
        else if (c[i]) m_flag[i] = 1'b0;
        if (c[i]) begin
          m_cnt_a[i] = acc[i] ? 1 : 0; m_sat_a[i] = 1'b0;
          m_cnt_b[i] = acc[i] ? 1 : 0; m_sat_b[i] = 1'b0;
        end else if (acc[i]) begin
          if (m_cnt_a[i] == (1 << WA) - 1) m_sat_a[i] = 1'b1; else m_cnt_a[i]++;
          if (m_cnt_b[i] == (1 << WB) - 1) m_sat_b[i] = 1'b1; else m_cnt_b[i]++;
        end
        if (acc[i] && !found) begin
          m_id  = i;
          found = 1;
        end
      end
      if (acc != 0) m_any = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    logic [NCh*WA-1:0] ea;
    logic [NCh*WB-1:0] eb;
    for (int i = 0; i < NCh; i++) begin
      ea[i*WA +: WA] = WA'(m_cnt_a[i]);
      eb[i*WB +: WB] = WB'(m_cnt_b[i]);
    end
    check({tag, ".trig_a"}, 64'(trg_a), 64'(m_trig));
    check({tag, ".lev_a"},  64'(lev_a), 64'(m_flag));
    check({tag, ".cnt_a"},  64'(cnt_a), 64'(ea));
    check({tag, ".sat_a"},  64'(sat_a), 64'(m_sat_a));
    check({tag, ".id_a"},   64'(id_a),  64'(m_id));
    check({tag, ".any_a"},  64'(any_a), 64'(m_any));
    check({tag, ".irq_a"},  64'(irq_a), 64'(|m_flag));
    check({tag, ".trig_b"}, 64'(trg_b), 64'(m_trig));
    check({tag, ".lev_b"},  64'(lev_b), 64'(m_flag));
    check({tag, ".cnt_b"},  64'(cnt_b), 64'(eb));
    check({tag, ".sat_b"},  64'(sat_b), 64'(m_sat_b));
    check({tag, ".id_b"},   64'(id_b),  64'(m_id));
    check({tag, ".any_b"},  64'(any_b), 64'(m_any));
    check({tag, ".irq_b"},  64'(irq_b), 64'(|m_flag));
  endtask

  task automatic step(input string tag, input logic r, input logic [NCh-1:0] t, e, c);
    @(negedge clk);
    rst_n = r; trig = t; en = e; clr = c;
    @(posedge clk);
    model_step(r, t, e, c);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [NCh-1:0] rc;

    step("reset", 1'b0, 4'hF, 4'hF, 4'h0);
    step("reset", 1'b0, 4'h0, 4'h0, 4'h0);
    check("rst_cnt", 64'(cnt_a), 64'd0);
    check("rst_irq", 64'(irq_a), 64'd0);

    // Disabled channel trigger: nothing changes
    step("masked", 1'b1, 4'b0100, 4'b1011, 4'h0);
    check("masked_any", 64'(any_a), 64'd0);
    check("masked_lev", 64'(lev_a), 64'd0);

    // Single event on ch1
    step("ev1", 1'b1, 4'b0010, 4'hF, 4'h0);
    check("ev1_trig", 64'(trg_a), 64'b0010);
    check("ev1_lev",  64'(lev_a), 64'b0010);
    check("ev1_cnt1", 64'(cnt_a[15:8]), 64'd1);
    check("ev1_id",   64'(id_a), 64'd1);
    check("ev1_any",  64'(any_a), 64'd1);
    check("ev1_irq",  64'(irq_a), 64'd1);
    step("ev1b", 1'b1, 4'b0000, 4'hF, 4'h0);
    check("ev1b_trig", 64'(trg_a), 64'd0);

    // Two channels at once; lowest index reported
    step("clrall", 1'b1, 4'b0000, 4'hF, 4'hF);
    check("clr_any", 64'(any_a), 64'd1);
    step("pair", 1'b1, 4'b0101, 4'hF, 4'h0);
    check("pair_id",  64'(id_a), 64'd0);
    check("pair_lev", 64'(lev_a), 64'b0101);
    check("pair_c0",  64'(cnt_a[7:0]), 64'd1);
    check("pair_c2",  64'(cnt_a[23:16]), 64'd1);

    // Saturation on the 2-bit instance, then clear
    for (int k = 0; k < 4; k++) step("sat3", 1'b1, 4'b1000, 4'hF, 4'h0);
    check("sat3_cnt", 64'(cnt_b[7:6]), 64'd3);
    check("sat3_sat", 64'(sat_b[3]), 64'd1);
    step("clr3", 1'b1, 4'b0000, 4'hF, 4'b1000);
    check("clr3_cnt", 64'(cnt_b[7:6]), 64'd0);
    check("clr3_sat", 64'(sat_b[3]), 64'd0);
    check("clr3_lev", 64'(lev_a[3]), 64'd0);

    // Clear coinciding with an event
    step("clrall2", 1'b1, 4'b0000, 4'hF, 4'hF);
    for (int k = 0; k < 5; k++) step("ch2x5", 1'b1, 4'b0100, 4'hF, 4'h0);
    check("ch2x5_cnt", 64'(cnt_a[23:16]), 64'd5);
    step("clrev", 1'b1, 4'b0100, 4'hF, 4'b0100);
    check("clrev_cnt", 64'(cnt_a[23:16]), 64'd1);
    check("clrev_lev", 64'(lev_a[2]), 64'd1);
    check("clrev_satb", 64'(sat_b[2]), 64'd0);

    // Reset mid-stream
    step("stream", 1'b1, 4'hF, 4'hF, 4'h0);
    step("midrst", 1'b0, 4'hF, 4'hF, 4'h0);
    check("midrst_cnt", 64'(cnt_a), 64'd0);
    check("midrst_trg", 64'(trg_a), 64'd0);
    check("midrst_any", 64'(any_a), 64'd0);
    step("post", 1'b1, 4'b0001, 4'hF, 4'h0);
    check("post_cnt0", 64'(cnt_a[7:0]), 64'd1);

    // Long burst saturates the 8-bit counter
    for (int k = 0; k < 260; k++) step("burst", 1'b1, 4'b0001, 4'hF, 4'h0);
    check("burst_cnt", 64'(cnt_a[7:0]), 64'd255);
    check("burst_sat", 64'(sat_a[0]), 64'd1);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      for (int i = 0; i < NCh; i++) rc[i] = ($urandom_range(0, 15) == 0);
      step("rand", ($urandom_range(0, 99) != 0), 4'($urandom), 4'($urandom | $urandom), rc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
